spram_arbiter_2p: RTL and testbench
===================================

SPRAM_ARBITER_2P -- requirements
Module: spram_arbiter_2p

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ROUND_ROBIN, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority with port A highest.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have `clk`, input, 1, the single clock; all logic is posedge `clk`.
REQ-003 The block SHALL have `rst`, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have `a_req` / `b_req`, input, 1, access request.
REQ-005 The block SHALL have `a_wen` / `b_wen`, input, 1, where 1 means write and 0 means read.
REQ-006 The block SHALL have `a_addr` / `b_addr`, input, [0:9], word address with bit 0 as the MSB.
REQ-007 The block SHALL have `a_din` / `b_din`, input, [0:7], write data.
REQ-008 The block SHALL have `a_gnt` / `b_gnt`, output, 1, a combinational grant meaning the access is accepted this cycle.
REQ-009 The block SHALL have `a_rvalid` / `b_rvalid`, output, 1, read data valid, asserted one cycle after a granted read.
REQ-010 The block SHALL have `a_dout` / `b_dout`, output, [0:7], read data, meaningful only while rvalid is 1.

Function
REQ-011 The block SHALL own exactly one 1024x8 single-port RAM and perform at most one access per cycle.
REQ-012 Request qualification:
- A requester SHALL hold req, wen, addr and din stable until it sees gnt high at a posedge.
- A request is consumed on any posedge where gnt is 1.
REQ-013 When only one req is high, that port SHALL be granted in the same cycle.
REQ-014 When both reqs are high and ROUND_ROBIN=1, the port named by the priority pointer `prio` SHALL be granted; `prio` then toggles to the other port on that posedge.
REQ-015 With ROUND_ROBIN=1, `prio` SHALL change only on a contended grant; an uncontested grant does not move it.
REQ-016 When both reqs are high and ROUND_ROBIN=0, port A SHALL always be granted.
REQ-017 a_gnt and b_gnt SHALL never both be 1, and gnt SHALL never be 1 while the matching req is 0.
REQ-018 RAM drive:
- ram wen is granted_req & granted_wen.
- ram addr and din are the granted port's values.
- When nothing is granted, ram wen SHALL be 0, and addr SHALL be held at its previous value with no read tag set.
REQ-019 Read latency:
- A granted read at cycle N SHALL produce rvalid=1 for exactly one cycle, N+1, on the granting port only, with dout equal to the RAM contents at the address as of the end of cycle N.
REQ-020 Writes SHALL produce no rvalid; written data SHALL be visible to a read granted in any later cycle.
REQ-021 Back-to-back reads SHALL sustain one result per cycle.
- The read tag register (`rd_pend`, `rd_port`) SHALL record only the most recent granted read.
REQ-022 dout of the non-target port SHALL hold its last value; it is not required to be zero.
REQ-023 Simultaneous write by A and read by B to the same address: only the winner SHALL execute that cycle; the loser executes later and observes the RAM state at its own grant cycle.

Reset
REQ-024 While rst=1, at each posedge:
- a_rvalid, b_rvalid and rd_pend SHALL be 0.
- prio SHALL be port A.
- a_dout and b_dout SHALL be 8'h00.
REQ-025 While rst=1, gnt outputs SHALL be 0 and no RAM write SHALL occur.
REQ-026 A read granted in the cycle rst rises SHALL be discarded, with no rvalid after reset.
REQ-027 RAM contents SHALL NOT be cleared by rst; they are zero only at simulation start.

Structure
REQ-028 A shared package SHALL define:
- SPRAM_AW=10 and SPRAM_DW=8.
- Port-select encoding PORT_A=1'b0, PORT_B=1'b1.
REQ-029 The RAM SHALL be one sub-module instance of the team's spram_1024x8; the arbiter adds no other memory.
REQ-030 The arbitration decision SHALL be combinational; prio, rd_pend, rd_port and the dout registers SHALL be the only state.

Verification
REQ-031 Write A then read A: A writes addr 10'h005 data 8'hA5 at cycle 1 and reads 10'h005 at cycle 2 -> a_rvalid=1 at cycle 3 with a_dout=8'hA5, and b_rvalid stays 0.
REQ-032 Contention, ROUND_ROBIN=1: A and B both request reads for 4 consecutive cycles after reset -> grants occur in order A, B, A, B, and each rvalid arrives 1 cycle after its grant.
REQ-033 Contention, ROUND_ROBIN=0: A and B both request continuously for 3 cycles -> a_gnt=1 on all 3 cycles and b_gnt=0 throughout.
REQ-034 Same-address conflict: A writes 10'h3FF data 8'h3C while B reads 10'h3FF, after reset with RAM=0 -> A granted first, then B granted next cycle, and b_dout=8'h3C.
REQ-035 Reset mid-read: B read is granted at cycle N and rst=1 at cycle N -> b_rvalid=0 at cycle N+1, prio=A, and a subsequent contended request grants A first.
REQ-036 Idle cycles: with no req for 5 cycles -> no gnt, no rvalid, and RAM contents unchanged as checked by a read-back of 3 prior-written addresses.

Source files
------------

// File: rtl/spram_arbiter_2p_pkg.sv
// Shared types and constants for the two-port arbiter in front of the 1024x8 single-port RAM.
package spram_arbiter_2p_pkg;

  localparam int SPRAM_AW = 10;
  localparam int SPRAM_DW = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // One requester's access, without the req bit (req only steers the arbiter).
  typedef struct packed {
    logic                wen;
    logic [SPRAM_AW-1:0] addr;
    logic [SPRAM_DW-1:0] din;
  } acc_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/spram_arbiter_2p_ram.sv
// 1024x8 single-port RAM with a registered address: read data appears the cycle after the access
// and stays put while en is low, because the address register only loads on an access.
module spram_1024x8
  import spram_arbiter_2p_pkg::*;
(
  input  logic                clk,
  input  logic                en_i,
  input  logic                wen_i,
  input  logic [SPRAM_AW-1:0] addr_i,
  input  logic [SPRAM_DW-1:0] din_i,
  output logic [SPRAM_DW-1:0] dout_o
);

  localparam int DEPTH = 1 << SPRAM_AW;

  // Contents start at zero and are deliberately never touched by any reset.
  logic [SPRAM_DW-1:0] mem_q [DEPTH] = '{default: '0};
  logic [SPRAM_AW-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (wen_i) begin
        mem_q[addr_i] <= din_i;
      end
      addr_q <= addr_i;
    end
  end

  assign dout_o = mem_q[addr_q];

endmodule

// File: rtl/spram_arbiter_2p.sv
// Two requesters share one single-port RAM; grants are combinational, reads return one cycle later.
// ROUND_ROBIN=1 alternates on contention, ROUND_ROBIN=0 always favours port A.
module spram_arbiter_2p
  import spram_arbiter_2p_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_wen,
  input  logic [0:SPRAM_AW-1] a_addr,
  input  logic [0:SPRAM_DW-1] a_din,
  input  logic                b_req,
  input  logic                b_wen,
  input  logic [0:SPRAM_AW-1] b_addr,
  input  logic [0:SPRAM_DW-1] b_din,
  output logic                a_gnt,
  output logic                b_gnt,
  output logic                a_rvalid,
  output logic                b_rvalid,
  output logic [0:SPRAM_DW-1] a_dout,
  output logic [0:SPRAM_DW-1] b_dout
);

  acc_t                acc [2];
  acc_t                win;
  logic                contended;
  logic                gnt_any;
  port_e               sel;
  port_e               prio_q, prio_d;
  port_e               rd_port_q, rd_port_d;
  logic                rd_pend_q, rd_pend_d;
  logic [1:0]          gnt_vec;
  logic [1:0]          rvalid_vec;
  logic [SPRAM_DW-1:0] dout_q [2];
  logic [SPRAM_DW-1:0] dout_d [2];
  logic [SPRAM_DW-1:0] ram_dout;

  assign acc[0] = '{wen: a_wen, addr: a_addr, din: a_din};
  assign acc[1] = '{wen: b_wen, addr: b_addr, din: b_din};

  // Grant decision; reset masks every request so nothing reaches the RAM.
  always_comb begin
    contended = a_req & b_req;
    gnt_any   = 1'b0;
    sel       = PORT_A;
    if (!rst) begin
      if (contended) begin
        gnt_any = 1'b1;
        sel     = (ROUND_ROBIN != 0) ? prio_q : PORT_A;
      end else if (a_req) begin
        gnt_any = 1'b1;
      end else if (b_req) begin
        gnt_any = 1'b1;
        sel     = PORT_B;
      end
    end
  end

  assign win = (sel == PORT_B) ? acc[1] : acc[0];

  always_comb begin
    prio_d    = prio_q;
    rd_pend_d = gnt_any & ~win.wen;
    rd_port_d = rd_port_q;
    if ((ROUND_ROBIN != 0) && contended) begin
      prio_d = other_port(prio_q);
    end
    if (gnt_any && !win.wen) begin
      rd_port_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= PORT_A;
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT_A;
    end else begin
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // Per-port grant, read-valid and held read data; the read tag steers RAM data to one port only.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam port_e PSEL = (gi == 0) ? PORT_A : PORT_B;

    assign gnt_vec[gi]    = gnt_any && (sel == PSEL);
    assign rvalid_vec[gi] = rd_pend_q && (rd_port_q == PSEL);
    assign dout_d[gi]     = rvalid_vec[gi] ? ram_dout : dout_q[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q[gi] <= '0;
      end else begin
        dout_q[gi] <= dout_d[gi];
      end
    end
  end

  spram_1024x8 u_ram (
    .clk    (clk),
    .en_i   (gnt_any),
    .wen_i  (gnt_any & win.wen),
    .addr_i (win.addr),
    .din_i  (win.din),
    .dout_o (ram_dout)
  );

  assign a_gnt    = gnt_vec[0];
  assign b_gnt    = gnt_vec[1];
  assign a_rvalid = rvalid_vec[0];
  assign b_rvalid = rvalid_vec[1];
  assign a_dout   = dout_d[0];
  assign b_dout   = dout_d[1];

  a_gnt_excl: assert property (@(posedge clk) !(a_gnt && b_gnt));
  a_gnt_req:  assert property (@(posedge clk) (!a_gnt || a_req) && (!b_gnt || b_req));

endmodule

// File: tb/tb_spram_arbiter_2p.sv
// Randomized bench for spram_arbiter_2p: a reference model predicts grants and read data,
// a monitor pops expected reads and checks rvalid/dout each cycle.
module tb_spram_arbiter_2p;
  import spram_arbiter_2p_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_req, a_wen, b_req, b_wen;
  logic [0:9] a_addr, b_addr;
  logic [0:7] a_din, b_din;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [0:7] a_dout, b_dout;

  logic       f_a_req, f_a_wen, f_b_req, f_b_wen;
  logic [0:9] f_a_addr, f_b_addr;
  logic [0:7] f_a_din, f_b_din;
  logic       f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid;
  logic [0:7] f_a_dout, f_b_dout;

  spram_arbiter_2p #(.ROUND_ROBIN(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_din(b_din),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_dout(a_dout), .b_dout(b_dout)
  );

  spram_arbiter_2p #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(f_a_req), .a_wen(f_a_wen), .a_addr(f_a_addr), .a_din(f_a_din),
    .b_req(f_b_req), .b_wen(f_b_wen), .b_addr(f_b_addr), .b_din(f_b_din),
    .a_gnt(f_a_gnt), .b_gnt(f_b_gnt), .a_rvalid(f_a_rvalid), .b_rvalid(f_b_rvalid),
    .a_dout(f_a_dout), .b_dout(f_b_dout)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mem_m [1024];
  port_e      prio_m = PORT_A;
  rd_t        qa[$];
  rd_t        qb[$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: grant rules from the arbitration policy, RAM as a plain array.
  always @(negedge clk) begin : ref_model
    bit         ea, eb;
    port_e      s;
    logic       w;
    logic [9:0] ad;
    logic [7:0] d;
    ea = 1'b0;
    eb = 1'b0;
    s  = PORT_A;
    if (rst) begin
      prio_m = PORT_A;
    end else if (a_req && b_req) begin
      s      = prio_m;
      prio_m = (s == PORT_A) ? PORT_B : PORT_A;
      ea     = (s == PORT_A);
      eb     = (s == PORT_B);
    end else begin
      ea = a_req;
      eb = b_req;
    end
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    if (ea || eb) begin
      w  = ea ? a_wen : b_wen;
      ad = ea ? a_addr : b_addr;
      d  = ea ? a_din : b_din;
      if (w) mem_m[ad] = d;
      else if (ea) qa.push_back('{cyc + 1, mem_m[ad]});
      else qb.push_back('{cyc + 1, mem_m[ad]});
    end
  end

  always @(negedge clk) begin : monitor
    bit ev;
    if (mon_en) begin
      ev = (qa.size() > 0) && (qa[0].cyc == cyc);
      chk("a_rvalid", a_rvalid, ev);
      if (ev) begin
        chk("a_dout", a_dout, qa[0].data);
        last_a = qa[0].data;
        void'(qa.pop_front());
      end else begin
        chk("a_dout_hold", a_dout, last_a);
      end
      ev = (qb.size() > 0) && (qb[0].cyc == cyc);
      chk("b_rvalid", b_rvalid, ev);
      if (ev) begin
        chk("b_dout", b_dout, qb[0].data);
        last_b = qb[0].data;
        void'(qb.pop_front());
      end else begin
        chk("b_dout_hold", b_dout, last_b);
      end
      if (rst) begin
        last_a = 8'h00;
        last_b = 8'h00;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one access on port p and hold it until granted (bounded wait).
  task automatic port_do(input bit p, input bit w, input logic [9:0] ad, input logic [7:0] d);
    bit got;
    got = 1'b0;
    if (!p) begin a_req = 1'b1; a_wen = w; a_addr = ad; a_din = d; end
    else    begin b_req = 1'b1; b_wen = w; b_addr = ad; b_din = d; end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if ((!p && a_gnt) || (p && b_gnt)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout port=%0d got=0 want=1", p);
    end
    @(posedge clk);
    #1;
    if (!p) begin a_req = 1'b0; a_wen = 1'b0; end
    else    begin b_req = 1'b0; b_wen = 1'b0; end
  endtask

  task automatic rand_seq(input bit p, input int n);
    logic [9:0] ad;
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      ad = 10'($urandom_range(0, 7)) ^ (($urandom_range(0, 1) == 1) ? 10'h3F8 : 10'h000);
      port_do(p, $urandom_range(0, 2) == 0, ad, 8'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
    rst = 1'b1;
    a_req = 0; a_wen = 0; a_addr = '0; a_din = '0;
    b_req = 0; b_wen = 0; b_addr = '0; b_din = '0;
    f_a_req = 0; f_a_wen = 0; f_a_addr = '0; f_a_din = '0;
    f_b_req = 0; f_b_wen = 0; f_b_addr = '0; f_b_din = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    // Requests during reset must be ignored, including the write.
    a_req = 1; a_wen = 1; a_addr = 10'h005; a_din = 8'hFF;
    b_req = 1; b_wen = 0; b_addr = 10'h005;
    tick(2);
    rst = 1'b0; a_req = 0; a_wen = 0; b_req = 0;
    tick(1);

    port_do(0, 1, 10'h005, 8'hA5);
    port_do(0, 0, 10'h005, 8'h00);
    port_do(1, 1, 10'h200, 8'h5A);
    tick(2);

    fork
      begin repeat (4) port_do(0, 0, 10'h005, 8'h00); end
      begin repeat (4) port_do(1, 0, 10'h200, 8'h00); end
    join
    tick(2);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    fork
      port_do(0, 1, 10'h3FF, 8'h3C);
      port_do(1, 0, 10'h3FF, 8'h00);
    join
    tick(1);

    fork
      begin rst = 1'b1; tick(2); rst = 1'b0; end
      port_do(0, 0, 10'h3FF, 8'h00);
      port_do(1, 0, 10'h005, 8'h00);
    join
    tick(1);

    tick(5);
    port_do(0, 0, 10'h005, 8'h00);
    port_do(1, 0, 10'h3FF, 8'h00);
    port_do(0, 0, 10'h200, 8'h00);

    for (int r = 0; r < 40; r++) begin
      fork
        rand_seq(0, $urandom_range(1, 6));
        rand_seq(1, $urandom_range(1, 6));
      join
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    tick(3);

    // Fixed-priority instance: A wins every contended cycle.
    f_a_req = 1; f_a_addr = 10'h001; f_b_req = 1; f_b_addr = 10'h002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fp_a_gnt", f_a_gnt, 1);
      chk("fp_b_gnt", f_b_gnt, 0);
      if (i > 0) chk("fp_a_rvalid", f_a_rvalid, 1);
      @(posedge clk);
      #1;
    end
    f_a_req = 0;
    @(negedge clk);
    chk("fp_b_gnt_alone", f_b_gnt, 1);
    chk("fp_a_gnt_idle", f_a_gnt, 0);
    chk("fp_a_rvalid_last", f_a_rvalid, 1);
    chk("fp_a_dout", f_a_dout, 8'h00);
    chk("fp_b_rvalid_early", f_b_rvalid, 0);
    @(posedge clk);
    #1;
    f_b_req = 0;
    @(negedge clk);
    chk("fp_b_rvalid", f_b_rvalid, 1);
    chk("fp_b_dout", f_b_dout, 8'h00);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
